data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit.sv | 130 +++++++++++++
 tb/tb_data_mem_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory for a stalling datapath: IDLE -> WAIT x WAIT_CYCLES -> DONE.
// Requests are latched on leaving IDLE; read and write commit on the WAIT-to-DONE edge.
module data_mem_unit #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_adr,
  input  logic [31:0] mem_out,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_in,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  conflict_q, conflict_d;
  logic [31:0]           mem_in_q, mem_in_d;
  logic [31:0]           mem [DEPTH];

  logic req;
  logic commit;
  logic misaligned;
  logic unused_adr_hi;

  assign req           = mem_read | mem_write;
  assign commit        = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign misaligned    = (off_q != 2'b00);
  assign unused_adr_hi = ^mem_adr[31:DEPTH_LOG2+2];

  // State register and transaction latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
      wr_q       <= 1'b0;
      conflict_q <= 1'b0;
      mem_in_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      conflict_q <= conflict_d;
      mem_in_q   <= mem_in_d;
    end
  end

  // Next-state logic; a request seen in DONE is deliberately ignored
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    conflict_d = conflict_q;
    mem_in_d   = mem_in_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d    = S_WAIT;
          cnt_d      = 4'(WAIT_CYCLES - 1);
          idx_d      = mem_adr[DEPTH_LOG2+1:2];
          off_d      = mem_adr[1:0];
          wdata_d    = mem_out;
          wr_d       = mem_write;
          conflict_d = mem_read & mem_write;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!wr_q) mem_in_d = misaligned ? 32'h0 : mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    case (state_q)
      S_IDLE: stall = req;
      S_WAIT: stall = 1'b1;
      S_DONE: begin
        done = 1'b1;
        err  = misaligned | conflict_q;
      end
      default: ;
    endcase
  end

  // Array has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (commit && wr_q && !misaligned) mem[idx_q] <= wdata_q;
  end

  assign mem_in      = mem_in_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed vector table, corner sequences, randomized
// traffic against an array-based reference model, and a latency sweep.
module tb_data_mem_unit;

  localparam int DL2 = 8;
  localparam int WC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_adr = '0, mem_out = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_in;
  logic        stall, done, err;
  logic [1:0]  dbg_state_unused;

  logic        sw_read = 1'b0;
  logic [31:0] sw_in1, sw_in15;
  logic        sw_stall1, sw_done1, sw_err1, sw_stall15, sw_done15, sw_err15;
  logic [1:0]  sw_dbg1_unused, sw_dbg15_unused;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [2**DL2];
  logic [31:0] ref_in = 32'h0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] exp_in;
    logic        exp_err;
    bit          chk_in;
  } vec_t;
  vec_t vecs [11];

  data_mem_unit #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .mem_adr(mem_adr), .mem_out(mem_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_in(mem_in),
    .stall(stall), .done(done), .err(err), .dbg_state_o(dbg_state_unused)
  );

  data_mem_unit #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .mem_adr(32'h0), .mem_out(32'h0),
    .mem_read(sw_read), .mem_write(1'b0), .mem_in(sw_in1),
    .stall(sw_stall1), .done(sw_done1), .err(sw_err1), .dbg_state_o(sw_dbg1_unused)
  );

  data_mem_unit #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst), .mem_adr(32'h0), .mem_out(32'h0),
    .mem_read(sw_read), .mem_write(1'b0), .mem_in(sw_in15),
    .stall(sw_stall15), .done(sw_done15), .err(sw_err15), .dbg_state_o(sw_dbg15_unused)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: word-addressed array, alignment and conflict rules
  task automatic model_access(input logic rd, input logic wr, input logic [31:0] adr,
                              input logic [31:0] data, output logic [31:0] exp_in,
                              output logic exp_err);
    int idx;
    bit mis;
    idx = int'(adr / 4) % (2 ** DL2);
    mis = (adr % 4) != 0;
    if (wr) begin
      if (!mis) ref_mem[idx] = data;
    end else if (rd) begin
      ref_in = mis ? 32'h0 : ref_mem[idx];
    end
    exp_in  = ref_in;
    exp_err = mis || (rd && wr);
  endtask

  // Drive one request at a negedge and follow it to DONE
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] adr,
                            input logic [31:0] data, input bit hold,
                            output logic [31:0] got_in, output logic got_err,
                            output int stalls);
    int cyc;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_adr = adr; mem_out = data;
    stalls = 0; cyc = 0;
    #1;
    while (!done && cyc < 40) begin
      if (stall) stalls++;
      @(negedge clk);
      cyc++;
      if (!hold) begin
        mem_read = 1'b0; mem_write = 1'b0; mem_adr = $urandom; mem_out = $urandom;
      end
      #1;
    end
    check32("done_seen", 32'(done), 32'd1);
    check32("stall_in_done", 32'(stall), 32'd0);
    got_in  = mem_in;
    got_err = err;
    if (!hold) begin
      @(negedge clk); #1;
      check32("idle_outputs", {29'd0, stall, done, err}, 32'd0);
    end
  endtask

  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] adr,
                        input logic [31:0] data);
    logic [31:0] exp_in, got_in;
    logic        exp_err, got_err;
    int          stalls;
    model_access(rd, wr, adr, data, exp_in, exp_err);
    run_access(rd, wr, adr, data, 1'b0, got_in, got_err, stalls);
    check32("mem_in", got_in, exp_in);
    check32("err", 32'(got_err), 32'(exp_err));
    check32("stall_cycles", 32'(stalls), 32'(1 + WC));
  endtask

  initial begin
    logic [31:0] got_in, exp_in, old20;
    logic        got_err, exp_err;
    int          stalls, n1, n15, cyc;
    bit          d1, d15;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h13,  32'h1,        32'h0,        1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h400, 32'hA5,       32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   32'h0,        32'hA5,       1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h44,  32'h12345678, 32'h0,        1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h44,  32'h0,        32'h12345678, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h7FC, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1};

    // Reset block
    repeat (3) @(negedge clk);
    #1;
    check32("reset_mem_in", mem_in, 32'h0);
    check32("reset_flags", {29'd0, stall, done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Give every word a defined value
    for (int i = 0; i < 2 ** DL2; i++) do_txn(1'b0, 1'b1, 32'(i * 4), $urandom);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      model_access(vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].data, exp_in, exp_err);
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].data, 1'b0, got_in, got_err, stalls);
      if (vecs[i].chk_in) check32($sformatf("vec%0d_mem_in", i), got_in, vecs[i].exp_in);
      check32($sformatf("vec%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
      check32($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(1 + WC));
    end

    // Held read: one done pulse, then a fresh transaction from IDLE
    model_access(1'b1, 1'b0, 32'h10, 32'h0, exp_in, exp_err);
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, got_in, got_err, stalls);
    check32("held_mem_in", got_in, exp_in);
    @(negedge clk); #1;
    check32("held_after_done", {30'd0, done, stall}, 32'd1);
    @(negedge clk);
    mem_read = 1'b0;
    cyc = 0;
    #1;
    while (!done && cyc < 40) begin
      @(negedge clk); #1; cyc++;
    end
    check32("held_second_done", 32'(done), 32'd1);
    check32("held_second_mem_in", mem_in, exp_in);
    @(negedge clk); #1;
    check32("held_done_single", 32'(done), 32'd0);

    // Reset during WAIT of a write to 0x20
    old20 = ref_mem[8];
    @(negedge clk);
    mem_write = 1'b1; mem_adr = 32'h20; mem_out = ~old20;
    @(negedge clk);
    mem_write = 1'b0;
    rst = 1'b1;
    #1;
    check32("rst_mid_stall", 32'(stall), 32'd0);
    check32("rst_mid_mem_in", mem_in, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ref_in = 32'h0;
    #1;
    check32("rst_after_flags", {29'd0, stall, done, err}, 32'd0);
    do_txn(1'b1, 1'b0, 32'h20, 32'h0);
    check32("rst_word_kept", ref_in, old20);

    // Randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int op;
      op = $urandom_range(0, 4);
      a  = {20'h0, 12'($urandom_range(0, 4095))};
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_txn(op >= 2 && op != 4, op < 2 || op == 4, a, $urandom);
    end

    // Latency sweep on the WAIT_CYCLES=1 and =15 instances
    @(negedge clk);
    sw_read = 1'b1;
    n1 = 0; n15 = 0; d1 = 0; d15 = 0;
    #1;
    for (int c = 0; c < 40 && !(d1 && d15); c++) begin
      if (sw_stall1) n1++;
      if (sw_stall15) n15++;
      if (sw_done1) d1 = 1;
      if (sw_done15) d15 = 1;
      @(negedge clk);
      sw_read = 1'b0;
      #1;
    end
    check32("sweep_done_seen", {30'd0, d1, d15}, 32'd3);
    check32("sweep_w1_stalls", 32'(n1), 32'd2);
    check32("sweep_w15_stalls", 32'(n15), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
